text_buffer_ctrl: RTL



---
 rtl/text_buffer_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: owns the 16x16 character buffer behind the text-box renderer.
// - Read port: char_code is the registered contents of cell char_xy (1-cycle latency, read-first).
// - Write port: round-robin arbitration between two requesters. Each accepted write takes one
//   IDLE cycle plus one WRITE cycle, and the ack is given in the WRITE cycle.
// - Clear: on clear_req, FILL_CHAR is written to all 256 cells, one cell per cycle.
// Optional build macro VBLANK_WRITE_ONLY_EN: buffer writes (WRITE and CLEAR) only happen in
// cycles with vblnk_in=1. WRITE holds and the clear counter pauses while vblnk_in is low.
module text_buffer_ctrl #(
   parameter logic [7:0] FILL_CHAR = 8'h20,
   parameter int         DEPTH     = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_xy,
   output logic [7:0] char_code,
   input  logic       vblnk_in,
   input  logic       req0,
   input  logic [7:0] addr0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic [7:0] addr1,
   input  logic [7:0] data1,
   output logic       ack1,
   input  logic       clear_req,
   output logic       clear_busy,
   output logic       clear_done
);

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   state_t     state, state_nxt;
   logic [7:0] mem [DEPTH];
   logic [7:0] cnt, cnt_nxt;
   logic       last_grant, last_grant_nxt;   // requester that won the most recent grant
   logic       grant, grant_nxt;             // requester served by the current WRITE
   logic [7:0] wr_addr, wr_addr_nxt;
   logic [7:0] wr_data, wr_data_nxt;
   logic       done_nxt;
   logic       wr_ok;
   logic       mem_we;
   logic [7:0] mem_addr, mem_data;

`ifdef VBLANK_WRITE_ONLY_EN
   assign wr_ok = vblnk_in;
`else
   logic unused_vblnk;
   assign unused_vblnk = vblnk_in;
   assign wr_ok        = 1'b1;
`endif

   // Next-state, arbitration and buffer write-port decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_nxt      = state;
      cnt_nxt        = cnt;
      last_grant_nxt = last_grant;
      grant_nxt      = grant;
      wr_addr_nxt    = wr_addr;
      wr_data_nxt    = wr_data;
      done_nxt       = 1'b0;
      ack0           = 1'b0;
      ack1           = 1'b0;
      clear_busy     = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = wr_addr;
      mem_data       = wr_data;
      case (state)
         IDLE: begin
            if (clear_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = 8'd0;
            end else if (req0 || req1) begin
               // NOTE: blocking assignments here, so grant_nxt is already updated when the lines below read it.
               grant_nxt      = (req0 && req1) ? ~last_grant : req1;
               last_grant_nxt = grant_nxt;
               wr_addr_nxt    = grant_nxt ? addr1 : addr0;
               wr_data_nxt    = grant_nxt ? data1 : data0;
               state_nxt      = WRITE;
            end
         end
         WRITE: begin
            if (wr_ok) begin
               mem_we    = 1'b1;
               ack0      = ~grant;
               ack1      = grant;
               state_nxt = IDLE;
            end
         end
         CLEAR: begin
            clear_busy = 1'b1;
            mem_addr   = cnt;
            mem_data   = FILL_CHAR;
            if (wr_ok) begin
               mem_we = 1'b1;
               if (cnt == 8'hFF) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A write that is pending in the reset cycle is dropped and is not acknowledged.
      if (rst) begin
         mem_we = 1'b0;
         ack0   = 1'b0;
         ack1   = 1'b0;
      end
   end

   // State register plus the latched write request, clear counter and clear_done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         wr_addr    <= 8'd0;
         wr_data    <= 8'd0;
         clear_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         last_grant <= last_grant_nxt;
         grant      <= grant_nxt;
         wr_addr    <= wr_addr_nxt;
         wr_data    <= wr_data_nxt;
         clear_done <= done_nxt;
      end
   end

   // Buffer write port, shared by the requesters and the clear sequencer.
   always_ff @(posedge clk) begin
      // NOTE: the RAM array has no reset, so it can map onto block RAM. The clear command is how the buffer gets initialised.
      if (mem_we) mem[mem_addr] <= mem_data;
   end

   // Renderer read port. It returns the old data when a write to the same cell happens in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) char_code <= 8'd0;
      else     char_code <= mem[char_xy];
   end

endmodule
